de_scoreboard: RTL
==================

# de_scoreboard

Hazard controller for the LC-3b pipeline's decode (DE) stage. It sits beside the decode datapath and tracks in-flight writers of R0–R7 and of the condition codes with per-register pending counters. It stalls DE on read-after-write hazards and gates issue into AGEX. It also drives the decode datapath's mux selects and its register-file and CC load enables.

## Interface
Parameters:
- CNT_W, 2, width of each pending counter; at most 3 writers are in flight (AGEX, MEM, SR).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- de_v  in  1  DE latch holds a valid instruction.
- de_ir  in  16  (lc3b_word) DE instruction.
- agex_stall  in  1  AGEX cannot accept a new instruction this cycle.
- flush  in  1  branch redirect; kills the DE instruction and, if `kill_agex_v`, the AGEX instruction.
- kill_agex_v  in  1  AGEX holds a valid instruction being killed by `flush`.
- kill_agex_ld_reg  in  1  the killed AGEX instruction writes a register.
- kill_agex_ld_cc  in  1  the killed AGEX instruction writes CC.
- kill_agex_drid  in  3  (lc3b_reg) destination of the killed AGEX instruction.
- wb_v  in  1  SR stage holds a valid retiring instruction.
- wb_ld_reg  in  1  retiring instruction writes a register.
- wb_ld_cc  in  1  retiring instruction writes CC.
- wb_drid  in  3  retiring destination register.
- ld_de  out  1  load FE→DE latch; 0 holds DE.
- agex_v_in  out  1  valid bit for the instruction entering AGEX; 0 inserts a bubble.
- agex_ld_reg_in  out  1  issued instruction writes a register.
- agex_ld_cc_in  out  1  issued instruction writes CC.
- idmux_sel  out  1  1 selects `ir[11:9]` as the second regfile read port (STB/STW).
- drmux_sel  out  1  1 forces destination R7 (JSR/JSRR, TRAP).
- load_regfile  out  1  equals `wb_v & wb_ld_reg`.
- load_cc  out  1  equals `wb_v & wb_ld_cc`.
- hazard  out  1  DE stalled on a RAW dependence (debug/perf).

## Operation
- **Opcode decode** on `de_ir[15:12]`:
  - Reads SR1 `[8:6]`: ADD, AND, NOT, SHF, LDB, LDW, STB, STW, JMP; also JSR when `ir[11]=0`.
  - Reads SR2 `[2:0]`: ADD/AND with `ir[5]=0`.
  - Reads `[11:9]`: STB, STW.
  - Reads CC: BR, except when nzp = 000.
  - Writes DR `[11:9]`: ADD, AND, NOT, SHF, LDB, LDW, LEA.
  - Writes R7: JSR, TRAP.
  - Writes CC: ADD, AND, NOT, SHF, LDB, LDW.
  - All other opcodes read and write nothing.
- **State:** `pend[0..7]` and `pend_cc`, each a CNT_W-bit counter. A register is ready iff its counter is 0.
- **Hazard detection:**
  - `hazard = de_v & ~flush & (any used source has pend≠0, or CC read with pend_cc≠0)`.
  - There is no same-cycle release credit. A source whose only writer retires this cycle still stalls, and becomes ready next cycle.
- **Issue and stall control:**
  - `issue = de_v & ~hazard & ~agex_stall & ~flush`.
  - `agex_v_in = issue`.
  - `ld_de = flush | ~(agex_stall | hazard)`.
  - `agex_ld_reg_in` and `agex_ld_cc_in` are the decoded write flags qualified by `issue`.
- **Counter update** (per counter, net of all sources in one cycle):
  - +1 if `issue` writes it.
  - −1 if `wb_v` retires a write to it.
  - −1 if `flush & kill_agex_v` and the killed instruction writes it.
  - Up to three simultaneous events on one register net to a single update; for example, +1 and −1 leaves the counter unchanged.
  - Counters never wrap. Overflow past 3 or underflow below 0 is a protocol error and is flagged by a bench assertion.
- **Mux selects and loads:** `idmux_sel`, `drmux_sel`, `load_regfile` and `load_cc` are combinational from the current inputs and are valid regardless of stall.

## Timing
- **Reset:** all counters = 0. All outputs are combinational from state and inputs. With `de_v=0`: `ld_de=1`, `agex_v_in=0`, `hazard=0`.
- **Issue latency:** 0 cycles. An instruction issues in the same cycle its hazards clear.
- **Back-to-back RAW:** producer issues at cycle t, is in AGEX at t+1, MEM at t+2, SR at t+3; the counter clears at the end of t+3. The dependent instruction issues at t+4, giving 3 stall cycles.
- **Reset during a stall:** counters clear on the next edge and DE issues on the following cycle.
- **Flush:** takes priority over hazard and `agex_stall`. There is no issue that cycle, and `ld_de=1` so the redirected fetch can load.

## Test plan
- **Reset:** reset with `de_v=1`, `ADD R1,R2,R3` → next cycle `agex_v_in=1`, `hazard=0`, all counters 0 before issue.
- **RAW stall:** `ADD R1,R2,R3` then `ADD R4,R1,R5`; wb of R1 presented 3 cycles after issue → `hazard=1` / `ld_de=0` for exactly 3 cycles, second ADD issues on the 4th.
- **Store source:** `STW R3,R6,#0` after `LDW R3` → `idmux_sel=1`, stall until R3 retires. With `ADD R1,R2,#5` (`ir[5]=1`), no stall on R5.
- **CC dependence:** `AND R0,R0,#0` then `BRz` → 3-cycle CC stall. `BR` with nzp=000 after ADD → no stall.
- **JSR / R7:** `JSR` → `drmux_sel=1`, `pend[7]=1`. Following `ADD R0,R7,#0` stalls. A simultaneous issue writing R7 and wb of R7 leaves `pend[7]` unchanged.
- **Flush:** flush with `kill_agex_v=1`, drid=2, ld_reg=1, while DE holds a dependent of R2 → no issue, `ld_de=1`, `pend[2]` decrements to 0. The next fetched reader of R2 issues without stall.

Source files
------------

// File: rtl/de_scoreboard.sv
// de_scoreboard: RAW hazard tracking, issue/stall control and decode-side
// mux selects for the LC-3b DE stage. Each architectural register and the
// condition codes have a pending-writer counter; a source is ready at zero.
module de_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de_v,
    input  logic [15:0] de_ir,
    input  logic        agex_stall,
    input  logic        flush,
    input  logic        kill_agex_v,
    input  logic        kill_agex_ld_reg,
    input  logic        kill_agex_ld_cc,
    input  logic [2:0]  kill_agex_drid,
    input  logic        wb_v,
    input  logic        wb_ld_reg,
    input  logic        wb_ld_cc,
    input  logic [2:0]  wb_drid,
    output logic        ld_de,
    output logic        agex_v_in,
    output logic        agex_ld_reg_in,
    output logic        agex_ld_cc_in,
    output logic        idmux_sel,
    output logic        drmux_sel,
    output logic        load_regfile,
    output logic        load_cc,
    output logic        hazard
);

    localparam int unsigned NREG = 8;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDW  = 4'b0110;
    localparam logic [3:0] OP_STW  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    logic [CNT_W-1:0] pend_q [NREG];
    logic [CNT_W-1:0] pend_d [NREG];
    logic [CNT_W-1:0] pend_cc_q;
    logic [CNT_W-1:0] pend_cc_d;

    logic [3:0] opcode;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] st_src;
    logic [2:0] dr;
    logic       rd_sr1;
    logic       rd_sr2;
    logic       rd_st;
    logic       rd_cc;
    logic       wr_reg;
    logic       wr_cc;
    logic       wr_r7;
    logic       src_busy;
    logic       issue;
    logic       unused_ir_bits;

    // Immediate-shift bits [4:3] never name a register.
    assign unused_ir_bits = ^de_ir[4:3];

    // Opcode decode into source/destination usage flags.
    always_comb begin
        opcode = de_ir[15:12];
        sr1    = de_ir[8:6];
        sr2    = de_ir[2:0];
        st_src = de_ir[11:9];
        rd_sr1 = 1'b0;
        rd_sr2 = 1'b0;
        rd_st  = 1'b0;
        rd_cc  = 1'b0;
        wr_reg = 1'b0;
        wr_cc  = 1'b0;
        wr_r7  = 1'b0;
        unique case (opcode)
            OP_ADD, OP_AND: begin
                rd_sr1 = 1'b1;
                rd_sr2 = ~de_ir[5];
                wr_reg = 1'b1;
                wr_cc  = 1'b1;
            end
            OP_NOT, OP_SHF, OP_LDB, OP_LDW: begin
                rd_sr1 = 1'b1;
                wr_reg = 1'b1;
                wr_cc  = 1'b1;
            end
            OP_STB, OP_STW: begin
                rd_sr1 = 1'b1;
                rd_st  = 1'b1;
            end
            OP_JMP:  rd_sr1 = 1'b1;
            OP_JSR: begin
                rd_sr1 = ~de_ir[11];
                wr_reg = 1'b1;
                wr_r7  = 1'b1;
            end
            OP_TRAP: begin
                wr_reg = 1'b1;
                wr_r7  = 1'b1;
            end
            OP_LEA:  wr_reg = 1'b1;
            OP_BR:   rd_cc  = (de_ir[11:9] != 3'b000);
            default: ;
        endcase
        dr = wr_r7 ? 3'd7 : de_ir[11:9];
    end

    // Hazard detection and issue/stall control; flush overrides everything.
    always_comb begin
        src_busy = (rd_sr1 && (pend_q[sr1]    != '0)) ||
                   (rd_sr2 && (pend_q[sr2]    != '0)) ||
                   (rd_st  && (pend_q[st_src] != '0)) ||
                   (rd_cc  && (pend_cc_q      != '0));
        hazard         = de_v & ~flush & src_busy;
        issue          = de_v & ~hazard & ~agex_stall & ~flush;
        agex_v_in      = issue;
        ld_de          = flush | ~(agex_stall | hazard);
        agex_ld_reg_in = issue & wr_reg;
        agex_ld_cc_in  = issue & wr_cc;
        idmux_sel      = rd_st;
        drmux_sel      = wr_r7;
        load_regfile   = wb_v & wb_ld_reg;
        load_cc        = wb_v & wb_ld_cc;
    end

    // Net counter update: issue adds a writer, retire and kill each remove one.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i]
                      + CNT_W'(issue && wr_reg && (dr == 3'(i)))
                      - CNT_W'(wb_v && wb_ld_reg && (wb_drid == 3'(i)))
                      - CNT_W'(flush && kill_agex_v && kill_agex_ld_reg &&
                               (kill_agex_drid == 3'(i)));
        end
        pend_cc_d = pend_cc_q
                  + CNT_W'(issue && wr_cc)
                  - CNT_W'(wb_v && wb_ld_cc)
                  - CNT_W'(flush && kill_agex_v && kill_agex_ld_cc);
    end

    // Pending-counter state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend_q[i] <= '0;
            end
            pend_cc_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend_q[i] <= pend_d[i];
            end
            pend_cc_q <= pend_cc_d;
        end
    end

endmodule
